store_trace_fifo: RTL and testbench

- Downstream observer of the single-cycle MIPS computer's data-memory bus (memwrite, dataadr, writedata, pc).
- Captures every committed store into a FIFO and checks stores against two programmable expected address/data pairs.
- Tracks a run/done state and raises pass/fail, so benches and future on-chip debug logic read results through a ready/valid port instead of probing dmem internals.

---
 rtl/store_trace_fifo.sv | 151 +++++++++++++++
 tb/tb_store_trace_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/store_trace_fifo.sv
// Store trace FIFO: captures committed stores from the MIPS data-memory bus and checks them
// against two expected address/data pairs. Optional capture timestamps via STORE_TRACE_TSTAMP_EN.
module store_trace_fifo #(
  parameter int DEPTH    = 8,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int PC_LIMIT = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     memwrite,
  input  logic [AW-1:0]            dataadr,
  input  logic [DW-1:0]            writedata,
  input  logic [31:0]              pc,
  input  logic [AW-1:0]            exp_adr0,
  input  logic [DW-1:0]            exp_data0,
  input  logic [AW-1:0]            exp_adr1,
  input  logic [DW-1:0]            exp_data1,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [AW-1:0]            rd_adr,
  output logic [DW-1:0]            rd_data,
  output logic [15:0]              rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     hit0,
  output logic                     hit1,
  output logic                     err,
  output logic                     done,
  output logic                     pass
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   PC_LIM   = 32'(PC_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
`ifdef STORE_TRACE_TSTAMP_EN
    logic [15:0]   stamp;
`endif
  } entry_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d, hit0_q, hit0_d, hit1_q, hit1_d, err_q, err_d, pass_q, pass_d;
  entry_t          mem_q [DEPTH];
  entry_t          wr_ent, head;
  logic            proc, pop, push;
  logic            a0_eq, a1_eq, d0_eq, d1_eq;

`ifdef STORE_TRACE_TSTAMP_EN
  logic [15:0]     stamp_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 stamp_q <= '0;
    else if (state_q == S_RUN) stamp_q <= stamp_q + 16'd1;
  end
`endif

  always_comb begin
    proc  = (state_q == S_RUN) & memwrite;
    pop   = (count_q != '0) & rd_ready;
    // A full FIFO still takes the store when the head leaves on the same edge.
    push  = proc & ((count_q != FULL_CNT) | pop);
    a0_eq = dataadr == exp_adr0;
    a1_eq = dataadr == exp_adr1;
    d0_eq = writedata == exp_data0;
    d1_eq = writedata == exp_data1;

    hit0_d = hit0_q | (proc & a0_eq & d0_eq);
    hit1_d = hit1_q | (proc & a1_eq & d1_eq);
    err_d  = err_q  | (proc & ((a0_eq & ~d0_eq) | (a1_eq & ~d1_eq)));
    ovf_d  = ovf_q  | (proc & ~push);

    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if ((hit0_d & hit1_d) | (pc > PC_LIM)) state_d = S_DONE;
      default: state_d = state_q;
    endcase

    pass_d = (state_d == S_DONE) & hit0_d & hit1_d & ~err_d & ~ovf_d;

    wr_ent      = '0;
    wr_ent.adr  = dataadr;
    wr_ent.data = writedata;
`ifdef STORE_TRACE_TSTAMP_EN
    wr_ent.stamp = stamp_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      hit0_q  <= 1'b0;
      hit1_q  <= 1'b0;
      err_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      hit0_q  <= hit0_d;
      hit1_q  <= hit1_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_ent;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign head     = mem_q[rptr_q];
  assign rd_valid = count_q != '0;
  assign rd_adr   = rd_valid ? head.adr  : '0;
  assign rd_data  = rd_valid ? head.data : '0;
`ifdef STORE_TRACE_TSTAMP_EN
  assign rd_stamp = rd_valid ? head.stamp : 16'h0;
`else
  assign rd_stamp = 16'h0;
`endif
  assign count    = count_q;
  assign overflow = ovf_q;
  assign hit0     = hit0_q;
  assign hit1     = hit1_q;
  assign err      = err_q;
  assign done     = state_q == S_DONE;
  assign pass     = pass_q;
endmodule

// File: tb/tb_store_trace_fifo.sv
// Directed bench for store_trace_fifo (DEPTH=8, PC_LIMIT=100); one task per scenario.
module tb_store_trace_fifo;
  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, memwrite = 1'b0, rd_ready = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0, pc = '0;
  logic [31:0] exp_adr0 = '0, exp_data0 = '0, exp_adr1 = '0, exp_data1 = '0;
  logic        rd_valid, overflow, hit0, hit1, err, done, pass;
  logic [31:0] rd_adr, rd_data;
  logic [15:0] rd_stamp;
  logic [3:0]  count;
  int          n_cmp = 0, n_err = 0;

  store_trace_fifo #(.DEPTH(8), .AW(32), .DW(32), .PC_LIMIT(100)) dut (
    .clk(clk), .reset(reset), .enable(enable), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .pc(pc), .exp_adr0(exp_adr0), .exp_data0(exp_data0),
    .exp_adr1(exp_adr1), .exp_data1(exp_data1), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_adr(rd_adr), .rd_data(rd_data), .rd_stamp(rd_stamp), .count(count),
    .overflow(overflow), .hit0(hit0), .hit1(hit1), .err(err), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    memwrite = 1'b0; rd_ready = 1'b0; enable = 1'b0; pc = '0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_cmp++; if ({rd_valid, overflow, hit0, hit1, err, done, pass} !== 7'b0) begin n_err++; $display("FAIL reset_flags got %b want 0", {rd_valid, overflow, hit0, hit1, err, done, pass}); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (rd_adr !== 32'h0 || rd_data !== 32'h0 || rd_stamp !== 16'h0) begin n_err++; $display("FAIL reset_head got %h/%h/%h want 0", rd_adr, rd_data, rd_stamp); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_match();
    exp_adr0 = 32'd1; exp_data0 = 32'h0C0C000A; exp_adr1 = 32'd63; exp_data1 = 32'h0;
    do_reset();
    enable = 1'b1; tick();
    store(32'd1, 32'h0C0C000A);
    n_cmp++; if (rd_valid !== 1'b1 || rd_adr !== 32'd1 || rd_data !== 32'h0C0C000A) begin n_err++; $display("FAIL match_first_head got %b %h %h want 1 1 0c0c000a", rd_valid, rd_adr, rd_data); end
    n_cmp++; if (hit0 !== 1'b1 || hit1 !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL match_first_flags got %b%b%b want 100", hit0, hit1, done); end
    store(32'd63, 32'h0);
    n_cmp++; if (hit1 !== 1'b1 || done !== 1'b1 || pass !== 1'b1 || count !== 4'd2) begin n_err++; $display("FAIL match_done got hit1=%b done=%b pass=%b cnt=%0d want 1 1 1 2", hit1, done, pass, count); end
    rd_ready = 1'b1; tick();
    n_cmp++; if (rd_adr !== 32'd63 || rd_data !== 32'h0 || count !== 4'd1) begin n_err++; $display("FAIL match_second_head got %h %h %0d want 3f 0 1", rd_adr, rd_data, count); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd0 || pass !== 1'b1) begin n_err++; $display("FAIL match_drained got v=%b cnt=%0d pass=%b want 0 0 1", rd_valid, count, pass); end
    rd_ready = 1'b0;
  endtask

  task automatic test_wrong_data();
    exp_adr0 = 32'd1; exp_data0 = 32'h0C0C000A; exp_adr1 = 32'd63; exp_data1 = 32'h0;
    do_reset();
    enable = 1'b1; tick();
    store(32'd63, 32'd5);
    n_cmp++; if (err !== 1'b1 || hit1 !== 1'b0) begin n_err++; $display("FAIL wrong_err got err=%b hit1=%b want 1 0", err, hit1); end
    store(32'd63, 32'd0);
    n_cmp++; if (hit1 !== 1'b1 || err !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL wrong_hit1 got hit1=%b err=%b done=%b want 1 1 0", hit1, err, done); end
    pc = 32'd101; tick();
    n_cmp++; if (done !== 1'b1 || pass !== 1'b0) begin n_err++; $display("FAIL wrong_pass got done=%b pass=%b want 1 0", done, pass); end
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    exp_adr0 = 32'hFFFF_FFF0; exp_adr1 = 32'hFFFF_FFF4;
    do_reset();
    enable = 1'b1; tick();
    for (int i = 0; i < 8; i++) store(32'd16 + 32'(i), 32'h11 * 32'(i));
    n_cmp++; if (count !== 4'd8 || overflow !== 1'b0) begin n_err++; $display("FAIL ovf_fill got cnt=%0d ovf=%b want 8 0", count, overflow); end
    n_cmp++; if (rd_adr !== 32'd16 || rd_data !== 32'h0) begin n_err++; $display("FAIL ovf_head0 got %h %h want 10 0", rd_adr, rd_data); end
    rd_ready = 1'b1; store(32'h99, 32'h9999);
    rd_ready = 1'b0;
    n_cmp++; if (count !== 4'd8 || overflow !== 1'b0) begin n_err++; $display("FAIL ovf_poppush got cnt=%0d ovf=%b want 8 0", count, overflow); end
    store(32'd24, 32'h88);
    n_cmp++; if (count !== 4'd8 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drop got cnt=%0d ovf=%b want 8 1", count, overflow); end
    rd_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      want = (i == 8) ? 32'h99 : 32'd16 + 32'(i);
      n_cmp++; if (rd_valid !== 1'b1 || rd_adr !== want) begin n_err++; $display("FAIL ovf_drain%0d got v=%b adr=%h want 1 %h", i, rd_valid, rd_adr, want); end
      tick();
    end
    n_cmp++; if (count !== 4'd0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got cnt=%0d v=%b want 0 0", count, rd_valid); end
    tick();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ovf_empty_pop got cnt=%0d want 0", count); end
    rd_ready = 1'b0;
  endtask

  task automatic test_pc_timeout();
    exp_adr0 = 32'd1; exp_data0 = 32'h0C0C000A; exp_adr1 = 32'd63; exp_data1 = 32'h0;
    do_reset();
    enable = 1'b1; tick();
    pc = 32'd99; tick();
    pc = 32'd100; tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL pc_at_limit got done=%b want 0", done); end
    pc = 32'd101; store(32'd63, 32'h0);
    n_cmp++; if (done !== 1'b1 || hit1 !== 1'b1 || count !== 4'd1 || pass !== 1'b0) begin n_err++; $display("FAIL pc_timeout got done=%b hit1=%b cnt=%0d pass=%b want 1 1 1 0", done, hit1, count, pass); end
    store(32'd1, 32'h0C0C000A);
    n_cmp++; if (hit0 !== 1'b0 || count !== 4'd1 || done !== 1'b1) begin n_err++; $display("FAIL pc_ignored got hit0=%b cnt=%0d done=%b want 0 1 1", hit0, count, done); end
  endtask

  task automatic test_async_reset();
    exp_adr0 = 32'hFFFF_FFF0; exp_adr1 = 32'hFFFF_FFF4;
    do_reset();
    enable = 1'b1; tick();
    for (int i = 0; i < 3; i++) store(32'd40 + 32'(i), 32'(i));
    n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL ar_pre got cnt=%0d want 3", count); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (count !== 4'd0 || rd_valid !== 1'b0 || rd_adr !== 32'h0 || done !== 1'b0) begin n_err++; $display("FAIL ar_immediate got cnt=%0d v=%b adr=%h done=%b want 0 0 0 0", count, rd_valid, rd_adr, done); end
    #1 reset = 1'b0;
    enable = 1'b0; store(32'd50, 32'd1); store(32'd51, 32'd2);
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ar_idle_ignore got cnt=%0d want 0", count); end
    enable = 1'b1; store(32'd52, 32'd3);
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ar_enable_edge got cnt=%0d want 0", count); end
    store(32'd53, 32'd4);
    n_cmp++; if (count !== 4'd1 || rd_adr !== 32'd53) begin n_err++; $display("FAIL ar_run got cnt=%0d adr=%h want 1 35", count, rd_adr); end
  endtask

  task automatic test_stamp();
    logic [15:0] s3, s7;
`ifdef STORE_TRACE_TSTAMP_EN
    s3 = 16'd3; s7 = 16'd7;
`else
    s3 = 16'd0; s7 = 16'd0;
`endif
    exp_adr0 = 32'hFFFF_FFF0; exp_adr1 = 32'hFFFF_FFF4;
    do_reset();
    enable = 1'b1; tick();
    for (int k = 0; k < 8; k++) begin
      memwrite = (k == 3 || k == 7); dataadr = 32'h100 + 32'(k); writedata = 32'(k);
      tick();
    end
    memwrite = 1'b0;
    n_cmp++; if (count !== 4'd2 || rd_adr !== 32'h103 || rd_stamp !== s3) begin n_err++; $display("FAIL stamp_first got cnt=%0d adr=%h st=%0d want 2 103 %0d", count, rd_adr, rd_stamp, s3); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    n_cmp++; if (rd_adr !== 32'h107 || rd_stamp !== s7) begin n_err++; $display("FAIL stamp_second got adr=%h st=%0d want 107 %0d", rd_adr, rd_stamp, s7); end
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_wrong_data();
    test_overflow();
    test_pc_timeout();
    test_async_reset();
    test_stamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
